// File: rtl/skip_if.sv
// Decode/issue-side bundle for the conditional skip unit: instruction
// presentation and issue handshake in, squash window status out.
interface skip_if #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 3,
  parameter int STATW = 16
);
  logic             dec_valid;
  logic [3:0]       opcode;
  logic [3:0]       funct;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] operand;
  logic [CNTW-1:0]  skip_len;
  logic             signed_mode;
  logic             issue;
  logic             flush;
  logic             squash;
  logic             skipping;
  logic [CNTW-1:0]  remaining;
  logic             skip_taken;
  logic [STATW-1:0] taken_count;

  modport master (
    output dec_valid, opcode, funct, acc, operand, skip_len,
           signed_mode, issue, flush,
    input  squash, skipping, remaining, skip_taken, taken_count
  );

  modport slave (
    input  dec_valid, opcode, funct, acc, operand, skip_len,
           signed_mode, issue, flush,
    output squash, skipping, remaining, skip_taken, taken_count
  );
endinterface

// File: rtl/skip_unit.sv
// Conditional-skip evaluation: decodes skip instructions, compares the
// accumulator against the operand and squashes the next 1..MAX_SKIP issues.
module skip_unit #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 3,
  parameter int STATW = 16
) (
  input  logic  CLK,
  input  logic  reset_n,
  skip_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SKIP = 1'b1
  } state_t;

  localparam logic [3:0] OP_ALU  = 4'd0;
  localparam logic [3:0] OP_SEQI = 4'd13;
  localparam logic [3:0] OP_SNEI = 4'd14;
  localparam logic [3:0] OP_SLTI = 4'd10;
  localparam logic [3:0] F_SEQ   = 4'd11;
  localparam logic [3:0] F_SNE   = 4'd3;
  localparam logic [3:0] F_SGT   = 4'd12;
  localparam logic [3:0] F_SLT   = 4'd15;
  localparam logic [3:0] F_SGE   = 4'd13;
  localparam logic [3:0] F_SLE   = 4'd14;

  state_t           state, state_n;
  logic [CNTW-1:0]  cnt, cnt_n;
  logic             accept;
  logic             skip_taken_q;
  logic [STATW-1:0] taken_count_q;
  logic             is_eq, is_lt, is_gt;
  logic             cond;

  always_comb begin
    is_eq = (bus.acc == bus.operand);
    if (bus.signed_mode) begin
      is_lt = ($signed(bus.acc) < $signed(bus.operand));
      is_gt = ($signed(bus.acc) > $signed(bus.operand));
    end else begin
      is_lt = (bus.acc < bus.operand);
      is_gt = (bus.acc > bus.operand);
    end
  end

  // Unlisted opcode/funct combinations never produce a skip.
  always_comb begin
    cond = 1'b0;
    case (bus.opcode)
      OP_ALU: begin
        case (bus.funct)
          F_SEQ:   cond = is_eq;
          F_SNE:   cond = !is_eq;
          F_SGT:   cond = is_gt;
          F_SLT:   cond = is_lt;
          F_SGE:   cond = !is_lt;
          F_SLE:   cond = !is_gt;
          default: cond = 1'b0;
        endcase
      end
      OP_SEQI: cond = is_eq;
      OP_SNEI: cond = !is_eq;
      OP_SLTI: cond = is_lt;
      default: cond = 1'b0;
    endcase
  end

  // Flush wins over everything; in SKIP the decoded instruction is a victim
  // and cannot open a new window.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (bus.flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dec_valid && cond) begin
            state_n = SKIP;
            cnt_n   = (bus.skip_len == '0) ? CNTW'(1) : bus.skip_len;
            accept  = 1'b1;
          end
        end
        SKIP: begin
          if (bus.issue) begin
            if (cnt <= CNTW'(1)) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt - CNTW'(1);
            end
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Debug statistics: pulse and saturating counter of accepted skips.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      skip_taken_q  <= 1'b0;
      taken_count_q <= '0;
    end else begin
      skip_taken_q <= accept;
      if (accept && (taken_count_q != {STATW{1'b1}})) begin
        taken_count_q <= taken_count_q + STATW'(1);
      end
    end
  end

  assign bus.skipping    = (state == SKIP);
  assign bus.squash      = (state == SKIP) && bus.issue;
  assign bus.remaining   = cnt;
  assign bus.skip_taken  = skip_taken_q;
  assign bus.taken_count = taken_count_q;

endmodule

// File: tb/tb_skip_unit.sv
// Scoreboard bench for skip_unit: directed vectors push hand-computed
// per-cycle expectations; a negedge monitor pops and compares them.
module tb_skip_unit;

  localparam int WIDTH = 16;
  localparam int CNTW  = 3;
  localparam int STATW = 4;

  typedef struct {
    string      tag;
    logic       sq;
    logic       sk;
    logic [2:0] rem;
    logic       st;
    logic [3:0] tc;
  } exp_t;

  logic CLK;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   tcModel = 0;
  exp_t expQ[$];

  skip_if #(.WIDTH(WIDTH), .CNTW(CNTW), .STATW(STATW)) bus ();

  skip_unit #(.WIDTH(WIDTH), .CNTW(CNTW), .STATW(STATW)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Inputs for one cycle plus the outputs expected during that same cycle.
  task automatic applyStimulus(input string tag, input bit rst, input bit dv,
                               input logic [3:0] op, input logic [3:0] fn,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] sl, input bit sm,
                               input bit iss, input bit fl,
                               input bit eSq, input bit eSk,
                               input logic [2:0] eRem, input bit eSt);
    exp_t e;
    reset_n         = rst;
    bus.dec_valid   = dv;
    bus.opcode      = op;
    bus.funct       = fn;
    bus.acc         = a;
    bus.operand     = b;
    bus.skip_len    = sl;
    bus.signed_mode = sm;
    bus.issue       = iss;
    bus.flush       = fl;
    if (!rst) tcModel = 0;
    else if (eSt) tcModel = (tcModel == 15) ? 15 : tcModel + 1;
    e.tag = tag; e.sq = eSq; e.sk = eSk; e.rem = eRem; e.st = eSt;
    e.tc  = 4'(tcModel);
    expQ.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input string tag, input bit iss, input bit eSq,
                      input bit eSk, input logic [2:0] eRem, input bit eSt);
    applyStimulus(tag, 1, 0, 4'd0, 4'd0, 16'h0, 16'h0, 3'd0, 1, iss, 0,
                  eSq, eSk, eRem, eSt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.tag, ".squash"},      int'(bus.squash),      int'(e.sq));
        checkOutput({e.tag, ".skipping"},    int'(bus.skipping),    int'(e.sk));
        checkOutput({e.tag, ".remaining"},   int'(bus.remaining),   int'(e.rem));
        checkOutput({e.tag, ".skip_taken"},  int'(bus.skip_taken),  int'(e.st));
        checkOutput({e.tag, ".taken_count"}, int'(bus.taken_count), int'(e.tc));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    reset_n = 1'b0;
    bus.dec_valid = 0; bus.opcode = 0; bus.funct = 0; bus.acc = 0;
    bus.operand = 0; bus.skip_len = 0; bus.signed_mode = 0;
    bus.issue = 0; bus.flush = 0;
    @(posedge CLK);
    #1;

    // Reset held with a true seq presented
    applyStimulus("rst0", 0, 1, 4'd0, 4'd11, 16'd5, 16'd5, 3'd2, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus("rst1", 0, 1, 4'd0, 4'd11, 16'd5, 16'd5, 3'd2, 1, 1, 0, 0, 0, 0, 0);
    idle("rel0", 1, 0, 0, 0, 0);
    idle("rel1", 0, 0, 0, 0, 0);

    // Signed slt: -1 < 1 taken
    applyStimulus("slt_s", 1, 1, 4'd0, 4'd15, 16'hFFFF, 16'h0001, 3'd0, 1, 0, 0, 0, 0, 0, 0);
    idle("slt_s1", 0, 0, 1, 1, 1);
    idle("slt_s2", 1, 1, 1, 1, 0);
    idle("slt_s3", 0, 0, 0, 0, 0);

    // Unsigned slt: 0xFFFF < 1 not taken
    applyStimulus("slt_u", 1, 1, 4'd0, 4'd15, 16'hFFFF, 16'h0001, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    idle("slt_u1", 0, 0, 0, 0, 0);

    // sge equal taken
    applyStimulus("sge", 1, 1, 4'd0, 4'd13, 16'h1234, 16'h1234, 3'd0, 1, 0, 0, 0, 0, 0, 0);
    idle("sge1", 1, 1, 1, 1, 1);
    idle("sge2", 0, 0, 0, 0, 0);

    // sne equal not taken
    applyStimulus("sne", 1, 1, 4'd0, 4'd3, 16'h1234, 16'h1234, 3'd0, 1, 0, 0, 0, 0, 0, 0);
    idle("sne1", 0, 0, 0, 0, 0);

    // slti signed: -32768 < 32767 taken
    applyStimulus("slti", 1, 1, 4'd10, 4'd0, 16'h8000, 16'h7FFF, 3'd0, 1, 0, 0, 0, 0, 0, 0);
    idle("slti1", 1, 1, 1, 1, 1);
    idle("slti2", 0, 0, 0, 0, 0);

    // sgt unsigned: 0x8000 > 0x7FFF taken
    applyStimulus("sgt_u", 1, 1, 4'd0, 4'd12, 16'h8000, 16'h7FFF, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    idle("sgt_u1", 1, 1, 1, 1, 1);
    idle("sgt_u2", 0, 0, 0, 0, 0);

    // sle 5 <= 4 not taken
    applyStimulus("sle", 1, 1, 4'd0, 4'd14, 16'd5, 16'd4, 3'd0, 1, 0, 0, 0, 0, 0, 0);
    idle("sle1", 0, 0, 0, 0, 0);

    // seqi skip_len=3, issue continuously high
    applyStimulus("multi", 1, 1, 4'd13, 4'd0, 16'd7, 16'd7, 3'd3, 1, 1, 0, 0, 0, 0, 0);
    idle("multi1", 1, 1, 1, 3, 1);
    idle("multi2", 1, 1, 1, 2, 0);
    idle("multi3", 1, 1, 1, 1, 0);
    idle("multi4", 1, 0, 0, 0, 0);

    // skip_len=0 means one squash
    applyStimulus("len0", 1, 1, 4'd13, 4'd0, 16'd7, 16'd7, 3'd0, 1, 1, 0, 0, 0, 0, 0);
    idle("len0_1", 1, 1, 1, 1, 1);
    idle("len0_2", 1, 0, 0, 0, 0);

    // Stall: skip_len=2, issue 1,0,0,1
    applyStimulus("stall", 1, 1, 4'd0, 4'd11, 16'd9, 16'd9, 3'd2, 1, 0, 0, 0, 0, 0, 0);
    idle("stall1", 1, 1, 1, 2, 1);
    idle("stall2", 0, 0, 1, 1, 0);
    idle("stall3", 0, 0, 1, 1, 0);
    idle("stall4", 1, 1, 1, 1, 0);
    idle("stall5", 0, 0, 0, 0, 0);

    // Nested true seq inside window is ignored; then back-to-back skip
    applyStimulus("nest", 1, 1, 4'd0, 4'd11, 16'd9, 16'd9, 3'd3, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("nest1", 1, 1, 4'd0, 4'd11, 16'd9, 16'd9, 3'd3, 1, 0, 0, 0, 1, 3, 1);
    applyStimulus("nest2", 1, 1, 4'd0, 4'd11, 16'd9, 16'd9, 3'd3, 1, 1, 0, 1, 1, 3, 0);
    idle("nest3", 1, 1, 1, 2, 0);
    applyStimulus("b2b", 1, 1, 4'd0, 4'd11, 16'd9, 16'd9, 3'd1, 1, 1, 0, 1, 1, 1, 0);
    applyStimulus("b2b1", 1, 1, 4'd0, 4'd11, 16'd9, 16'd9, 3'd1, 1, 1, 0, 0, 0, 0, 0);
    idle("b2b2", 1, 1, 1, 1, 1);
    idle("b2b3", 0, 0, 0, 0, 0);

    // Flush with remaining=2
    applyStimulus("flush", 1, 1, 4'd0, 4'd11, 16'd1, 16'd1, 3'd3, 1, 0, 0, 0, 0, 0, 0);
    idle("flush1", 1, 1, 1, 3, 1);
    applyStimulus("flush2", 1, 0, 4'd0, 4'd0, 16'd0, 16'd0, 3'd0, 1, 0, 1, 0, 1, 2, 0);
    idle("flush3", 1, 0, 0, 0, 0);
    idle("flush4", 1, 0, 0, 0, 0);

    // Flush together with a true snei in IDLE
    applyStimulus("flsnei", 1, 1, 4'd14, 4'd0, 16'd1, 16'd2, 3'd1, 1, 0, 1, 0, 0, 0, 0);
    idle("flsnei1", 0, 0, 0, 0, 0);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      applyStimulus("sat", 1, 1, 4'd0, 4'd11, 16'd3, 16'd3, 3'd0, 1, 1, 0, 0, 0, 0, 0);
      idle("sat1", 1, 1, 1, 1, 1);
    end

    // Async reset mid-window
    applyStimulus("arst", 1, 1, 4'd0, 4'd11, 16'd3, 16'd3, 3'd3, 1, 0, 0, 0, 0, 0, 0);
    idle("arst1", 0, 0, 1, 3, 1);
    applyStimulus("arst2", 0, 0, 4'd0, 4'd0, 16'd0, 16'd0, 3'd0, 1, 1, 0, 0, 0, 0, 0);
    idle("arst3", 1, 0, 0, 0, 0);
    applyStimulus("arst4", 1, 1, 4'd0, 4'd11, 16'd3, 16'd3, 3'd0, 1, 0, 0, 0, 0, 0, 0);
    idle("arst5", 1, 1, 1, 1, 1);
    idle("arst6", 0, 0, 0, 0, 0);

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge CLK);
    if (expQ.size() != 0) begin
      bad++;
      total++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
